// File: rtl/alu_exec_unit.sv
// EX-stage execution unit: decodes ALUOp/func3/func7 and executes RV32I/RV64I integer ops in one cycle.
// M-extension ops optionally run on an iterative radix-2 multiply/divide datapath behind a ready/valid handshake.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | accepting ops; ALU ops complete at the accepting edge
// S_RUN  | iterating a mul/div, one step per edge, in_ready low
module alu_exec_unit #(
   parameter int XLEN     = 32,
   parameter bit ENABLE_M = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      ALUOp,
   input  logic [2:0]      func3,
   input  logic            func7_5,
   input  logic            func7_0,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal
);

   localparam int SW = $clog2(XLEN);

   // M ops share the 5'b10xxx block with func3 in the low bits
   typedef enum logic [4:0] {
      OP_ADD    = 5'h00,
      OP_SUB    = 5'h01,
      OP_SLL    = 5'h02,
      OP_SLT    = 5'h03,
      OP_SLTU   = 5'h04,
      OP_XOR    = 5'h05,
      OP_SRL    = 5'h06,
      OP_SRA    = 5'h07,
      OP_OR     = 5'h08,
      OP_AND    = 5'h09,
      OP_ILL    = 5'h0F,
      OP_MUL    = 5'h10,
      OP_MULH   = 5'h11,
      OP_MULHSU = 5'h12,
      OP_MULHU  = 5'h13,
      OP_DIV    = 5'h14,
      OP_DIVU   = 5'h15,
      OP_REM    = 5'h16,
      OP_REMU   = 5'h17
   } op_e;

   typedef enum logic {S_IDLE, S_RUN} state_e;

   state_e          r_state;
   state_e          w_state_nx;
   op_e             w_dec_op;
   logic            w_dec_is_m;
   logic            w_accept;
   logic            w_last;

   logic [SW-1:0]   w_shamt;
   logic [XLEN-1:0] w_sra;
   logic [XLEN-1:0] w_alu_res;

   op_e             r_op;
   logic [SW-1:0]   r_cnt;
   logic [XLEN-1:0] r_hi;
   logic [XLEN-1:0] r_lo;
   logic [XLEN-1:0] r_b;
   logic [XLEN-1:0] r_a;
   logic            r_neg;
   logic            r_bz;

   logic            w_a_signed;
   logic            w_b_signed;
   logic            w_neg;
   logic [XLEN-1:0] w_a_mag;
   logic [XLEN-1:0] w_b_mag;

   logic [XLEN:0]     w_mul_sum;
   logic [XLEN:0]     w_div_sh;
   logic [XLEN:0]     w_div_sub;
   logic              w_div_ge;
   logic              w_is_div;
   logic [XLEN-1:0]   w_hi_nx;
   logic [XLEN-1:0]   w_lo_nx;
   logic [2*XLEN-1:0] w_prod;
   logic [2*XLEN-1:0] w_prod_s;
   logic [XLEN-1:0]   w_quo_s;
   logic [XLEN-1:0]   w_rem_s;
   logic [XLEN-1:0]   w_m_res;

   logic            r_out_valid;
   logic [XLEN-1:0] r_result;
   logic            r_zero;
   logic            r_illegal;

   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign zero      = r_zero;
   assign illegal   = r_illegal;

   assign w_accept = in_valid && in_ready;
   assign w_last   = (r_cnt == SW'(XLEN - 1));

   // ---------------- decode ----------------
   always_comb begin
      w_dec_op = OP_ADD;
      case (ALUOp)
         2'b00: w_dec_op = OP_ADD;
         2'b01: w_dec_op = OP_SUB;
         default: begin
            if (func7_0) begin
               if (ALUOp == 2'b10 && ENABLE_M) w_dec_op = op_e'({2'b10, func3});
               else                            w_dec_op = OP_ILL;
            end else begin
               case (func3)
                  3'b000:  w_dec_op = (func7_5 && ALUOp == 2'b10) ? OP_SUB : OP_ADD;
                  3'b001:  w_dec_op = OP_SLL;
                  3'b010:  w_dec_op = OP_SLT;
                  3'b011:  w_dec_op = OP_SLTU;
                  3'b100:  w_dec_op = OP_XOR;
                  3'b101:  w_dec_op = func7_5 ? OP_SRA : OP_SRL;
                  3'b110:  w_dec_op = OP_OR;
                  default: w_dec_op = OP_AND;
               endcase
            end
         end
      endcase
   end

   assign w_dec_is_m = w_dec_op[4];

   // ---------------- single-cycle ALU ----------------
   assign w_shamt = op_b[SW-1:0];
   assign w_sra   = $signed(op_a) >>> w_shamt;

   always_comb begin
      w_alu_res = '0;
      case (w_dec_op)
         OP_ADD:  w_alu_res = op_a + op_b;
         OP_SUB:  w_alu_res = op_a - op_b;
         OP_SLL:  w_alu_res = op_a << w_shamt;
         OP_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         OP_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         OP_XOR:  w_alu_res = op_a ^ op_b;
         OP_SRL:  w_alu_res = op_a >> w_shamt;
         OP_SRA:  w_alu_res = w_sra;
         OP_OR:   w_alu_res = op_a | op_b;
         OP_AND:  w_alu_res = op_a & op_b;
         default: w_alu_res = '0;
      endcase
   end

   // ---------------- operand magnitudes and result sign at acceptance ----------------
   always_comb begin
      w_a_signed = 1'b0;
      w_b_signed = 1'b0;
      w_neg      = 1'b0;
      case (w_dec_op)
         OP_MULH, OP_DIV: begin
            w_a_signed = 1'b1;
            w_b_signed = 1'b1;
            w_neg      = op_a[XLEN-1] ^ op_b[XLEN-1];
         end
         OP_MULHSU: begin
            w_a_signed = 1'b1;
            w_neg      = op_a[XLEN-1];
         end
         OP_REM: begin
            w_a_signed = 1'b1;
            w_b_signed = 1'b1;
            w_neg      = op_a[XLEN-1];
         end
         default: ;
      endcase
   end

   assign w_a_mag = (w_a_signed && op_a[XLEN-1]) ? -op_a : op_a;
   assign w_b_mag = (w_b_signed && op_b[XLEN-1]) ? -op_b : op_b;

   // ---------------- iterative step: hi/lo hold product or remainder/quotient ----------------
   assign w_is_div  = r_op[2];
   assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
   assign w_div_sh  = {r_hi, r_lo[XLEN-1]};
   assign w_div_sub = w_div_sh - {1'b0, r_b};
   assign w_div_ge  = ~w_div_sub[XLEN];

   always_comb begin
      if (w_is_div) begin
         w_hi_nx = w_div_ge ? w_div_sub[XLEN-1:0] : w_div_sh[XLEN-1:0];
         w_lo_nx = {r_lo[XLEN-2:0], w_div_ge};
      end else begin
         w_hi_nx = w_mul_sum[XLEN:1];
         w_lo_nx = {w_mul_sum[0], r_lo[XLEN-1:1]};
      end
   end

   assign w_prod   = {w_hi_nx, w_lo_nx};
   assign w_prod_s = r_neg ? -w_prod : w_prod;
   assign w_quo_s  = r_neg ? -w_lo_nx : w_lo_nx;
   assign w_rem_s  = r_neg ? -w_hi_nx : w_hi_nx;

   // divide-by-zero bypasses the sign fix-up entirely
   always_comb begin
      w_m_res = '0;
      case (r_op)
         OP_MUL:                       w_m_res = w_prod_s[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: w_m_res = w_prod_s[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              w_m_res = r_bz ? '1 : w_quo_s;
         OP_REM, OP_REMU:              w_m_res = r_bz ? r_a : w_rem_s;
         default:                      w_m_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_op  <= OP_ADD;
         r_cnt <= '0;
         r_hi  <= '0;
         r_lo  <= '0;
         r_b   <= '0;
         r_a   <= '0;
         r_neg <= 1'b0;
         r_bz  <= 1'b0;
      end else if (w_accept && w_dec_is_m) begin
         r_op  <= w_dec_op;
         r_cnt <= '0;
         r_hi  <= '0;
         r_lo  <= w_a_mag;
         r_b   <= w_b_mag;
         r_a   <= op_a;
         r_neg <= w_neg;
         r_bz  <= (op_b == '0);
      end else if (r_state == S_RUN) begin
         r_hi  <= w_hi_nx;
         r_lo  <= w_lo_nx;
         r_cnt <= r_cnt + SW'(1);
      end
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE:  if (w_accept && w_dec_is_m) w_state_nx = S_RUN;
         S_RUN:   if (w_last) w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (r_state == S_IDLE);
   end

   // ---------------- result register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_zero      <= 1'b0;
         r_illegal   <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         r_illegal   <= 1'b0;
         if (w_accept && !w_dec_is_m) begin
            r_out_valid <= 1'b1;
            r_result    <= w_alu_res;
            r_zero      <= (w_alu_res == '0);
            r_illegal   <= (w_dec_op == OP_ILL);
         end else if (r_state == S_RUN && w_last) begin
            r_out_valid <= 1'b1;
            r_result    <= w_m_res;
            r_zero      <= (w_m_res == '0);
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: table of single-cycle ALU vectors plus hand-written
// sequences for multi-cycle mul/div, reset abort and an M-disabled build.
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        nm_in_valid;
   logic [1:0]  ALUOp;
   logic [2:0]  func3;
   logic        func7_5;
   logic        func7_0;
   logic [31:0] op_a;
   logic [31:0] op_b;

   logic        in_ready,    nm_in_ready;
   logic        out_valid,   nm_out_valid;
   logic [31:0] result,      nm_result;
   logic        zero,        nm_zero;
   logic        illegal,     nm_illegal;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_exec_unit #(.XLEN(32), .ENABLE_M(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .ALUOp(ALUOp), .func3(func3), .func7_5(func7_5), .func7_0(func7_0),
      .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .result(result),
      .zero(zero), .illegal(illegal)
   );

   alu_exec_unit #(.XLEN(32), .ENABLE_M(1'b0)) dut_nm (
      .clk(clk), .rst(rst), .in_valid(nm_in_valid), .in_ready(nm_in_ready),
      .ALUOp(ALUOp), .func3(func3), .func7_5(func7_5), .func7_0(func7_0),
      .op_a(op_a), .op_b(op_b), .out_valid(nm_out_valid), .result(nm_result),
      .zero(nm_zero), .illegal(nm_illegal)
   );

   typedef struct {
      logic [1:0]  aluop;
      logic [2:0]  f3;
      logic        f75;
      logic        f70;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        ill;
   } vec_t;

   vec_t vt[16];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] aluop, input logic [2:0] f3, input logic f75,
                        input logic f70, input logic [31:0] a, input logic [31:0] b);
      ALUOp   = aluop;
      func3   = f3;
      func7_5 = f75;
      func7_0 = f70;
      op_a    = a;
      op_b    = b;
   endtask

   // caller is at #1 after an edge; op is accepted at the next edge and checked just after it
   task automatic apply_alu(input vec_t v, input string name);
      drive(v.aluop, v.f3, v.f75, v.f70, v.a, v.b);
      in_valid = 1'b1;
      @(posedge clk); #1;
      check({name, "_valid"},   64'(out_valid), 64'd1);
      check({name, "_result"},  64'(result),    64'(v.res));
      check({name, "_zero"},    64'(zero),      64'(v.res == 32'd0));
      check({name, "_illegal"}, 64'(illegal),   64'(v.ill));
      check({name, "_ready"},   64'(in_ready),  64'd1);
      in_valid = 1'b0;
   endtask

   task automatic run_m(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
      int cyc;
      logic ready_seen;
      drive(2'b10, f3, 1'b0, 1'b1, a, b);
      check({name, "_ready_before"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid   = 1'b0;
      cyc        = 0;
      ready_seen = 1'b0;
      while (!out_valid && cyc < 100) begin
         if (in_ready) ready_seen = 1'b1;
         @(posedge clk); #1;
         cyc++;
      end
      check({name, "_latency"},   64'(cyc),        64'd32);
      check({name, "_busy_ready"}, 64'(ready_seen), 64'd0);
      check({name, "_result"},    64'(result),     64'(exp));
      check({name, "_zero"},      64'(zero),       64'(exp == 32'd0));
      check({name, "_illegal"},   64'(illegal),    64'd0);
      check({name, "_ready_done"}, 64'(in_ready),  64'd1);
   endtask

   initial begin : main
      vec_t v;
      int   seen;

      vt[0]  = '{2'b10, 3'b000, 1'b1, 1'b0, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0};
      vt[1]  = '{2'b10, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0};
      vt[2]  = '{2'b10, 3'b011, 1'b0, 1'b0, 32'd1,         32'hFFFF_FFFF, 32'd1,         1'b0};
      vt[3]  = '{2'b10, 3'b111, 1'b0, 1'b0, 32'h0000_00F0, 32'h0000_000F, 32'd0,         1'b0};
      vt[4]  = '{2'b00, 3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2,         32'd1,         1'b0};
      vt[5]  = '{2'b01, 3'b000, 1'b0, 1'b0, 32'd3,         32'd3,         32'd0,         1'b0};
      vt[6]  = '{2'b11, 3'b000, 1'b1, 1'b0, 32'd5,         32'd7,         32'd12,        1'b0};
      vt[7]  = '{2'b10, 3'b001, 1'b0, 1'b0, 32'd1,         32'h0000_0021, 32'd2,         1'b0};
      vt[8]  = '{2'b10, 3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0};
      vt[9]  = '{2'b10, 3'b011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0};
      vt[10] = '{2'b10, 3'b100, 1'b0, 1'b0, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 1'b0};
      vt[11] = '{2'b10, 3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_001F, 32'd1,         1'b0};
      vt[12] = '{2'b10, 3'b110, 1'b0, 1'b0, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0};
      vt[13] = '{2'b11, 3'b101, 1'b1, 1'b0, 32'hF000_0000, 32'h0000_0404, 32'hFF00_0000, 1'b0};
      vt[14] = '{2'b11, 3'b000, 1'b0, 1'b1, 32'd5,         32'd7,         32'd0,         1'b1};
      vt[15] = '{2'b11, 3'b010, 1'b0, 1'b0, 32'h8000_0000, 32'd0,         32'd1,         1'b0};

      rst = 1'b1;
      in_valid = 1'b0;
      nm_in_valid = 1'b0;
      drive(2'b00, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready",   64'(in_ready),  64'd1);
      check("rst_valid",   64'(out_valid), 64'd0);
      check("rst_result",  64'(result),    64'd0);
      check("rst_zero",    64'(zero),      64'd0);
      check("rst_illegal", 64'(illegal),   64'd0);
      rst = 1'b0;

      // back-to-back single-cycle ops, one per edge
      for (int i = 0; i < 16; i++) apply_alu(vt[i], $sformatf("alu%0d", i));

      @(posedge clk); #1;
      check("idle_valid",  64'(out_valid), 64'd0);
      check("idle_hold",   64'(result),    64'd1);

      run_m("mulh",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
      run_m("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      // a new op is accepted in the same cycle the mul result is valid
      v = '{2'b10, 3'b000, 1'b0, 1'b0, 32'd3, 32'd4, 32'd7, 1'b0};
      apply_alu(v, "after_m");
      run_m("mul",    3'b000, 32'hFFFF_FFFF, 32'd3,         32'hFFFF_FFFD);
      run_m("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd3,         32'hFFFF_FFFF);
      run_m("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      run_m("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
      run_m("divu0",  3'b101, 32'd7,         32'd0,         32'hFFFF_FFFF);
      run_m("remu0",  3'b111, 32'd7,         32'd0,         32'd7);
      run_m("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD);
      run_m("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF);
      run_m("div0_s", 3'b100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF);

      // reset ten cycles into a divide aborts it
      drive(2'b10, 3'b100, 1'b0, 1'b1, 32'd1000, 32'd3);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_ready",  64'(in_ready),  64'd1);
      check("abort_valid",  64'(out_valid), 64'd0);
      check("abort_result", 64'(result),    64'd0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      check("abort_no_late_valid", 64'(seen), 64'd0);

      // M-disabled build
      drive(2'b10, 3'b000, 1'b0, 1'b1, 32'd3, 32'd4);
      nm_in_valid = 1'b1;
      @(posedge clk); #1;
      check("nm_mul_valid",   64'(nm_out_valid), 64'd1);
      check("nm_mul_illegal", 64'(nm_illegal),   64'd1);
      check("nm_mul_result",  64'(nm_result),    64'd0);
      check("nm_mul_zero",    64'(nm_zero),      64'd1);
      check("nm_mul_ready",   64'(nm_in_ready),  64'd1);
      drive(2'b10, 3'b000, 1'b0, 1'b0, 32'd3, 32'd4);
      @(posedge clk); #1;
      check("nm_add_valid",   64'(nm_out_valid), 64'd1);
      check("nm_add_illegal", 64'(nm_illegal),   64'd0);
      check("nm_add_result",  64'(nm_result),    64'd7);
      nm_in_valid = 1'b0;
      @(posedge clk); #1;
      check("nm_idle_valid",  64'(nm_out_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised successor of the combinational ALU-control decoder: decodes ALUOp/func3/func7 and executes the operation, registering the result.
- Covers the full RV32I/RV64I integer op set (ALU ops in 1 cycle) and, optionally, the M extension (multiply/divide) through an iterative radix-2 datapath with a ready/valid handshake.
- Sits in the EX stage between the operand muxes and the EX/MEM register; the main control stalls on in_ready low.

Parameters:
- XLEN, 32, operand/result width; power of 2, 8 to 64.
- ENABLE_M, 1, 1 = MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU implemented; 0 = those encodings flagged illegal.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept an operation this cycle
- ALUOp  input  2  00 load/store add, 01 branch sub, 10 R-type, 11 I-type arithmetic
- func3  input  3  instruction funct3
- func7_5  input  1  instruction bit 30 (SUB/SRA select)
- func7_0  input  1  instruction bit 25 (M-extension select)
- op_a  input  XLEN  operand A (rs1)
- op_b  input  XLEN  operand B (rs2 or immediate)
- out_valid  output  1  result valid, one-cycle pulse
- result  output  XLEN  registered result
- zero  output  1  result==0, registered alongside result
- illegal  output  1  unsupported encoding, pulses with out_valid

Behaviour:
- Reset: state=IDLE, in_ready=1 after reset, out_valid=0, result=0, zero=0, illegal=0, iteration counter=0. Reset mid-operation aborts the operation; no out_valid is produced for it.
- An operation is accepted on a rising edge where in_valid && in_ready. Operands and decoded op are captured at that edge and never re-sampled afterwards.
- Decode:
  - ALUOp 00 → ADD; ALUOp 01 → SUB.
  - ALUOp 10, func7_0=0, by func3: 000 ADD (SUB if func7_5), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if func7_5), 110 OR, 111 AND.
  - ALUOp 11: as ALUOp 10 but func7_5 ignored for func3=000 (always ADD); honoured only for 101 (SRAI).
  - ALUOp 10, func7_0=1: M op by func3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
- Shifts use op_b[log2(XLEN)-1:0] only. SLT is signed, SLTU unsigned; the result is zero-extended 0/1. ADD/SUB wrap modulo 2^XLEN.
- ALU ops: state stays IDLE; result, zero and out_valid are registered at the accepting edge. Latency 1, throughput 1 per cycle, in_ready stays 1.
- M ops (ENABLE_M=1): IDLE→RUN at the accepting edge; in_ready=0 in RUN.
  - RUN performs one shift-add (mul) or restoring shift-subtract (div) step per cycle on magnitudes, with sign fix-up at the end.
  - After exactly XLEN edges in RUN (counter 0..XLEN-1), RUN→IDLE and out_valid/result/zero are registered at that edge. Latency XLEN edges from acceptance.
  - in_ready returns to 1 in the same cycle out_valid is high, so a new op may be accepted in that cycle.
- MUL returns the low XLEN bits. MULH/MULHSU/MULHU return the high XLEN bits of the 2·XLEN product, with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
- Divide by zero: DIV/DIVU → all ones; REM/REMU → op_a. Same latency as a normal divide.
- Signed overflow (op_a = most-negative, op_b = −1): DIV → op_a; REM → 0.
- ENABLE_M=0, or a func7_0=1 encoding under ALUOp≠10: completes as a 1-cycle op with result=0, zero=1, illegal=1 for that out_valid pulse.
- out_valid is deasserted in every cycle with no completing op; result and zero hold their last values.
- No output backpressure: the consumer must take the result in its out_valid cycle.

Test Plan:
- Reset, then ALUOp=10, func3=000, func7_5=1, op_a=5, op_b=7 → 1 edge later out_valid=1, result=0xFFFFFFFE, zero=0; in_ready stays 1.
- Back-to-back ALU ops SRA(0x80000000 >> 4), SLTU(1, 0xFFFFFFFF), AND(0xF0, 0x0F) on consecutive cycles → results 0xF8000000, 1, 0 (zero=1) on three consecutive cycles.
- MULH 0xFFFFFFFF×0xFFFFFFFF → result 0x00000000; MULHU with the same operands → 0xFFFFFFFE; each arrives exactly 32 edges after acceptance, with in_ready=0 for those 32 cycles.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM with the same operands → 0; DIVU 7/0 → 0xFFFFFFFF; REMU 7/0 → 7.
- Assert rst 10 cycles into a DIV → next cycle in_ready=1, out_valid=0, result=0; no late out_valid is ever produced for the aborted op.
- ENABLE_M=0 build: MUL 3×4 → 1 edge later out_valid=1, illegal=1, result=0; next op ADD 3+4 → result 7, illegal=0.
